axi_max_txn_splitter: RTL and testbench

- Read/write address-channel sequencer in front of an axi_if master port.
- Accepts one linear byte-range command at a time and issues INCR bursts.
- No burst exceeds Max_Transaction_Bytes or crosses a Max_Transaction_Bytes-aligned boundary, so no burst crosses a 4KB boundary.
- Signals completion when the last burst address is accepted.

---
 rtl/axi_split_pkg.sv | 17 +
 rtl/axi_split_chunk_calc.sv | 31 +++
 rtl/axi_max_txn_splitter.sv | 140 ++++++++++++++
 tb/tb_axi_max_txn_splitter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_split_pkg.sv
// Shared types and constants for the AXI max-transaction splitter.
package axi_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AxSIZE encoding for a full-width beat of a DATA_WIDTH-bit bus.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_split_chunk_calc.sv
// Combinational burst sizing: largest chunk that fits before the next
// MAX_TXN_BYTES-aligned boundary, and the matching AxLEN.
module axi_split_chunk_calc #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned BYTES_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_TXN_BYTES = 64
) (
  input  logic [ADDR_WIDTH-1:0]  cur_addr,
  input  logic [BYTES_WIDTH-1:0] remaining,
  output logic [BYTES_WIDTH-1:0] chunk,
  output logic [7:0]             ax_len
);

  localparam int unsigned OFF_W      = $clog2(MAX_TXN_BYTES);
  localparam int unsigned BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [OFF_W-1:0]       offset;
  logic [BYTES_WIDTH-1:0] to_bound;
  logic [BYTES_WIDTH-1:0] beats;
  logic                   unused_addr_hi;

  assign offset         = cur_addr[OFF_W-1:0];
  assign unused_addr_hi = ^cur_addr[ADDR_WIDTH-1:OFF_W];

  assign to_bound = BYTES_WIDTH'(MAX_TXN_BYTES) - BYTES_WIDTH'(offset);
  assign chunk    = (remaining < to_bound) ? remaining : to_bound;
  assign beats    = chunk >> BEAT_SHIFT;
  assign ax_len   = 8'(beats - BYTES_WIDTH'(1));

endmodule

// File: rtl/axi_max_txn_splitter.sv
// Splits a linear byte-range command into INCR bursts that never exceed or
// cross a MAX_TXN_BYTES boundary. Optional counters: AXI_MAX_TXN_SPLITTER_STATS_EN.
module axi_max_txn_splitter
  import axi_split_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned MAX_TXN_BYTES = 64,
  parameter int unsigned BYTES_WIDTH   = 12
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [BYTES_WIDTH-1:0] cmd_bytes,
  input  logic [ID_WIDTH-1:0]    cmd_id,
  output logic                   ax_valid,
  input  logic                   ax_ready,
  output logic [ADDR_WIDTH-1:0]  ax_addr,
  output logic [ID_WIDTH-1:0]    ax_id,
  output logic [7:0]             ax_len,
  output logic [2:0]             ax_size,
  output logic [1:0]             ax_burst,
  output logic                   done,
  output logic [ID_WIDTH-1:0]    done_id,
  output logic                   busy
`ifdef AXI_MAX_TXN_SPLITTER_STATS_EN
  ,
  output logic [31:0]            stat_cmds,
  output logic [31:0]            stat_bursts
`endif
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_MASK  = ~ADDR_WIDTH'(BEAT_BYTES - 1);
  localparam logic [BYTES_WIDTH-1:0] BYTES_MASK = ~BYTES_WIDTH'(BEAT_BYTES - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BYTES_WIDTH-1:0] rem_q, rem_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;

  logic [BYTES_WIDTH-1:0] chunk;
  logic [7:0]             len_calc;
  logic [BYTES_WIDTH-1:0] cmd_bytes_al;

  assign cmd_bytes_al = cmd_bytes & BYTES_MASK;

  axi_split_chunk_calc #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BYTES_WIDTH   (BYTES_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_TXN_BYTES (MAX_TXN_BYTES)
  ) u_chunk_calc (
    .cur_addr  (addr_q),
    .remaining (rem_q),
    .chunk     (chunk),
    .ax_len    (len_calc)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    cmd_ready = 1'b0;
    ax_valid  = 1'b0;
    ax_len    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    done_id   = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr & ADDR_MASK;
          rem_d   = cmd_bytes_al;
          id_d    = cmd_id;
          state_d = (cmd_bytes_al == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ax_valid = 1'b1;
        busy     = 1'b1;
        ax_len   = len_calc;
        if (ax_ready) begin
          // Address wraps naturally; chunks end on a boundary, so wrap lands on 0.
          addr_d = addr_q + ADDR_WIDTH'(chunk);
          rem_d  = rem_q - chunk;
          if (rem_q == chunk) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        done_id = id_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ax_addr  = addr_q;
  assign ax_id    = id_q;
  assign ax_size  = axi_size(DATA_WIDTH);
  assign ax_burst = AXI_BURST_INCR;

`ifdef AXI_MAX_TXN_SPLITTER_STATS_EN
  logic [31:0] cmds_q, bursts_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmds_q   <= '0;
      bursts_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_valid && cmds_q != '1) cmds_q <= cmds_q + 32'd1;
      if (ax_valid && ax_ready && bursts_q != '1) bursts_q <= bursts_q + 32'd1;
    end
  end

  assign stat_cmds   = cmds_q;
  assign stat_bursts = bursts_q;
`endif

endmodule

// File: tb/tb_axi_max_txn_splitter.sv
// Directed self-checking bench for axi_max_txn_splitter.
module tb_axi_max_txn_splitter;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [11:0] cmd_bytes;
  logic [3:0]  cmd_id;
  logic        ax_valid;
  logic        ax_ready;
  logic [15:0] ax_addr;
  logic [3:0]  ax_id;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic        done;
  logic [3:0]  done_id;
  logic        busy;
`ifdef AXI_MAX_TXN_SPLITTER_STATS_EN
  logic [31:0] stat_cmds;
  logic [31:0] stat_bursts;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  axi_max_txn_splitter #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .ID_WIDTH      (4),
    .MAX_TXN_BYTES (64),
    .BYTES_WIDTH   (12)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_bytes   (cmd_bytes),
    .cmd_id      (cmd_id),
    .ax_valid    (ax_valid),
    .ax_ready    (ax_ready),
    .ax_addr     (ax_addr),
    .ax_id       (ax_id),
    .ax_len      (ax_len),
    .ax_size     (ax_size),
    .ax_burst    (ax_burst),
    .done        (done),
    .done_id     (done_id),
    .busy        (busy)
`ifdef AXI_MAX_TXN_SPLITTER_STATS_EN
    ,
    .stat_cmds   (stat_cmds),
    .stat_bursts (stat_bursts)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // Presents a command for one cycle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [15:0] a, input logic [11:0] b, input logic [3:0] id);
    cmd_addr  = a;
    cmd_bytes = b;
    cmd_id    = id;
    cmd_valid = 1'b1;
    check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_burst(input string tag, input logic [15:0] a, input logic [7:0] len,
                             input logic [3:0] id);
    check({tag, "_valid"}, 32'(ax_valid), 32'd1);
    check({tag, "_addr"},  32'(ax_addr),  32'(a));
    check({tag, "_len"},   32'(ax_len),   32'(len));
    check({tag, "_id"},    32'(ax_id),    32'(id));
    check({tag, "_busy"},  32'(busy),     32'd1);
    check({tag, "_crdy"},  32'(cmd_ready), 32'd0);
  endtask

  task automatic check_done(input string tag, input logic [3:0] id);
    check({tag, "_done"},    32'(done),     32'd1);
    check({tag, "_done_id"}, 32'(done_id),  32'(id));
    check({tag, "_axvalid"}, 32'(ax_valid), 32'd0);
    check({tag, "_busy"},    32'(busy),     32'd0);
    check({tag, "_crdy"},    32'(cmd_ready), 32'd0);
    step();
    check({tag, "_done_low"}, 32'(done),     32'd0);
    check({tag, "_idle_rdy"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_id    = '0;
    ax_ready  = 1'b1;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_ax_valid",  32'(ax_valid),  32'd0);
    check("rst_ax_addr",   32'(ax_addr),   32'd0);
    check("rst_ax_id",     32'(ax_id),     32'd0);
    check("rst_ax_len",    32'(ax_len),    32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_done_id",   32'(done_id),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ax_size",   32'(ax_size),   32'd2);
    check("rst_ax_burst",  32'(ax_burst),  32'd1);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Single aligned 64-byte burst.
    send_cmd(16'h0000, 12'd64, 4'd3);
    check_burst("t1_b0", 16'h0000, 8'd15, 4'd3);
    check("t1_size",  32'(ax_size),  32'd2);
    check("t1_burst", 32'(ax_burst), 32'd1);
    step();
    check_done("t1", 4'd3);

    // Split at the 0x40 boundary, back-to-back bursts.
    send_cmd(16'h0030, 12'd40, 4'd5);
    check_burst("t2_b0", 16'h0030, 8'd3, 4'd5);
    step();
    check_burst("t2_b1", 16'h0040, 8'd5, 4'd5);
    step();
    check_done("t2", 4'd5);

    // Address wrap to 0.
    send_cmd(16'hFFF0, 12'd32, 4'd9);
    check_burst("t3_b0", 16'hFFF0, 8'd3, 4'd9);
    step();
    check_burst("t3_b1", 16'h0000, 8'd3, 4'd9);
    step();
    check_done("t3", 4'd9);

    // Zero-length command; low (sub-beat) byte bits ignored as well.
    send_cmd(16'h1234, 12'd3, 4'd7);
    check_done("t4", 4'd7);

    // Backpressure: burst held stable for 10 cycles.
    ax_ready = 1'b0;
    send_cmd(16'h0000, 12'd128, 4'd2);
    for (int i = 0; i < 10; i++) begin
      check_burst("t5_hold", 16'h0000, 8'd15, 4'd2);
      step();
    end
    check_burst("t5_hold_last", 16'h0000, 8'd15, 4'd2);
    ax_ready = 1'b1;
    step();
    check_burst("t5_b1", 16'h0040, 8'd15, 4'd2);
    step();
    check_done("t5", 4'd2);

    // Reset during the second burst.
    send_cmd(16'h0100, 12'd128, 4'd4);
    check_burst("t6_b0", 16'h0100, 8'd15, 4'd4);
    step();
    check_burst("t6_b1", 16'h0140, 8'd15, 4'd4);
    aresetn = 1'b0;
    #1;
    check("t6_rst_axvalid", 32'(ax_valid),  32'd0);
    check("t6_rst_busy",    32'(busy),      32'd0);
    check("t6_rst_done",    32'(done),      32'd0);
    check("t6_rst_crdy",    32'(cmd_ready), 32'd1);
    check("t6_rst_addr",    32'(ax_addr),   32'd0);
`ifdef AXI_MAX_TXN_SPLITTER_STATS_EN
    check("t6_stat_cmds",   stat_cmds,      32'd0);
    check("t6_stat_bursts", stat_bursts,    32'd0);
`endif
    @(negedge aclk);
    step();
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_post_done",    32'(done),      32'd0);
      check("t6_post_axvalid", 32'(ax_valid),  32'd0);
      check("t6_post_crdy",    32'(cmd_ready), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
